// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults, queued-entry layout and arbitration-flag encoding for writeback_unit.
package wb_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   typedef enum logic {ARB_ALU = 1'b0, ARB_LD = 1'b1} arb_t;
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;
endpackage

// File: rtl/wb_if.sv
// wb_if: valid/ready result channel from an execution source into writeback_unit.
interface wb_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   modport master (output valid, addr, data, input ready);
   modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order FIFO with occupancy and per-entry tag visibility (top KW bits of each entry).
module wb_fifo #(
   parameter int W = 37,
   parameter int KW = 5,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              dout,
   output logic [PW:0]               count,
   output logic                      full,
   output logic                      empty,
   output logic [DEPTH-1:0][KW-1:0]  tags,
   output logic [DEPTH-1:0]          occ
);
   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wp, rp;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   assign dout = mem[rp];
   assign full = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
   // slot i is live when its distance from the read pointer is below count
   always_comb
      for (int i = 0; i < DEPTH; i++) begin
         occ[i] = {1'b0, PW'(i) - rp} < count;
         tags[i] = mem[i][W-1 -: KW];
      end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: round-robin ALU/load result arbiter feeding an in-order FIFO that drains to the register file.
// Optional WB_R0_DISCARD_EN: register 0 is hardwired zero, so writes to it are accepted but dropped.
module writeback_unit import wb_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_if.slave                  alu,
   wb_if.slave                  ld,
   output logic [DATA_W-1:0]    rf_D,
   output logic [ADDR_W-1:0]    rf_DA,
   output logic                 rf_RL,
   output logic [2**ADDR_W-1:0] pending,
   output logic                 full
);
   localparam int PW = $clog2(DEPTH);
   localparam int W = ADDR_W + DATA_W;
`ifdef WB_R0_DISCARD_EN
   localparam bit R0_DISCARD = 1'b1;
`else
   localparam bit R0_DISCARD = 1'b0;
`endif
   arb_t                     last;
   logic                     both, gl, room, acc, push, empty;
   logic [ADDR_W-1:0]        a;
   logic [DATA_W-1:0]        d;
   logic [W-1:0]             dout;
   logic [PW:0]              count;
   logic [DEPTH-1:0][ADDR_W-1:0] tags;
   logic [DEPTH-1:0]         occ;
   always_comb begin
      both = alu.valid & ld.valid;
      gl = ld.valid & (!alu.valid | last == ARB_ALU);
      room = count < (PW+1)'(DEPTH);
      alu.ready = !gl & room;
      ld.ready = gl & room;
      acc = (alu.valid & alu.ready) | (ld.valid & ld.ready);
      a = gl ? ld.addr : alu.addr;
      d = gl ? ld.data : alu.data;
      push = acc & !(R0_DISCARD & a == '0);
   end
   wb_fifo #(.W(W), .KW(ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(!empty), .din({a, d}),
      .dout(dout), .count(count), .full(full), .empty(empty), .tags(tags), .occ(occ)
   );
   // only contested transfers move the round-robin flag
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last <= ARB_ALU;
         rf_D <= '0;
         rf_DA <= '0;
         rf_RL <= 1'b0;
      end else begin
         if (both & room) last <= gl ? ARB_LD : ARB_ALU;
         rf_RL <= !empty;
         if (!empty) {rf_DA, rf_D} <= dout;
      end
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (occ[i]) pending[tags[i]] = 1'b1;
   end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed test-plan sequences plus random traffic against a queue-based reference model.
module tb_writeback_unit;
   import wb_pkg::*;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rf_D;
   logic [4:0]  rf_DA;
   logic        rf_RL;
   logic [31:0] pending;
   logic        full;
   int          n_chk = 0;
   int          n_pass = 0;
   entry_t      q[$];
   bit          last_ld = 1'b0;
   logic        e_rl = 1'b0;
   logic [31:0] e_d = '0;
   logic [4:0]  e_da = '0;

   wb_if #(.DATA_W(32), .ADDR_W(5)) alu_if ();
   wb_if #(.DATA_W(32), .ADDR_W(5)) ld_if ();

   writeback_unit #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .alu(alu_if.slave), .ld(ld_if.slave),
      .rf_D(rf_D), .rf_DA(rf_DA), .rf_RL(rf_RL), .pending(pending), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] exp_pending();
      logic [31:0] p = '0;
      foreach (q[i]) p[q[i].addr] = 1'b1;
      return p;
   endfunction

   task automatic check_outputs();
      chk("rf_RL", rf_RL, e_rl);
      chk("rf_D", rf_D, e_d);
      chk("rf_DA", rf_DA, e_da);
      chk("pending", pending, exp_pending());
      chk("full", full, q.size() == DEPTH);
   endtask

   // one clock cycle, entered and left at a falling edge
   task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ldd);
      bit room, gl;
      entry_t e;
      alu_if.valid = av; alu_if.addr = aa; alu_if.data = ad;
      ld_if.valid = lv; ld_if.addr = la; ld_if.data = ldd;
      #1;
      room = q.size() < DEPTH;
      gl = (av && lv) ? !last_ld : lv;
      if (av) chk("alu_ready", alu_if.ready, !gl && room);
      if (lv) chk("ld_ready", ld_if.ready, gl && room);
      check_outputs();
      @(posedge clk);
      e_rl = q.size() > 0;
      if (e_rl) begin
         e = q.pop_front();
         e_d = e.data;
         e_da = e.addr;
      end
      if (room && (av || lv)) begin
         e.addr = gl ? la : aa;
         e.data = gl ? ldd : ad;
`ifdef WB_R0_DISCARD_EN
         if (e.addr != 0) q.push_back(e);
`else
         q.push_back(e);
`endif
         if (av && lv) last_ld = gl;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      alu_if.valid = 0; alu_if.addr = 0; alu_if.data = 0;
      ld_if.valid = 0; ld_if.addr = 0; ld_if.data = 0;
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      step(1, 3, 32'hDEADBEEF, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 4; i++) step(1, 5'(1 + i), 32'(100 + i), 1, 5'(11 + i), 32'(200 + i));
      idle(3);
      for (int i = 0; i < 4; i++) step(1, 5'(20 + i), 32'(300 + i), 1, 5'd30, 32'(400 + i));
      idle(3);
      step(1, 5, 1, 0, 0, 0);
      step(0, 0, 0, 1, 5, 2);
      idle(3);
      step(1, 0, 32'h12345678, 0, 0, 0);
      idle(3);
      step(1, 7, 32'h77, 1, 8, 32'h88);
      alu_if.valid = 0; ld_if.valid = 0;
      #2 rst_n = 1'b0;
      q.delete();
      last_ld = 1'b0; e_rl = 1'b0; e_d = '0; e_da = '0;
      #1 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
              $urandom_range(0, 2) != 0, 5'($urandom), $urandom);
      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
